// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: run-time configurable UART receiver with a show-ahead FIFO.
//   The frame format is selected at run time:
//     - bit period: CLK_PER_BIT << baud_sel
//     - 5..MAX_DATA data bits, sent LSB first
//     - optional even/odd parity bit
//     - one or two stop bits
//   Each bit is decided by a 3-sample majority vote around the middle of the bit.
//   Received words are queued in the FIFO with per-word parity and framing error flags.
// Ports:
//   clk, rst                     system clock, synchronous active-high reset
//   rx                           asynchronous serial input, idles high
//   baud_sel, data_len,          frame format, latched at each start edge
//   parity_en, parity_odd, stop2
//   rd_data, rd_perr, rd_ferr    FIFO head entry (zero while the FIFO is empty)
//   rd_valid, rd_ready           FIFO not empty / pop request
//   overrun                      one-cycle pulse when a word is dropped on a full FIFO
//   busy                         receiver FSM is not idle
module uart_rx_cfg #(
  parameter int CLK_PER_BIT = 32,
  parameter int MAX_DATA    = 9,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  input  logic [1:0]          baud_sel,
  input  logic [3:0]          data_len,
  input  logic                parity_en,
  input  logic                parity_odd,
  input  logic                stop2,
  output logic [MAX_DATA-1:0] rd_data,
  output logic                rd_perr,
  output logic                rd_ferr,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                overrun,
  output logic                busy
);
  // One extra bit so the counter can hold the longest period, CLK_PER_BIT << 3.
  localparam int CNT_W   = $clog2(CLK_PER_BIT * 8) + 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = MAX_DATA + 2;
  localparam logic [3:0] MAX_LEN = 4'(MAX_DATA);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_WAIT_HI, S_PUSH
  } state_t;

  state_t state_reg, state_next;

  logic rx_meta_reg, rx_s_reg, rx_prev_reg;
  logic [CNT_W-1:0] cnt_reg, period_reg, half;
  logic [3:0] len_reg, len_eff, bit_idx_reg;
  logic par_en_reg, par_odd_reg, stop2_reg;
  logic s0_reg, s1_reg, par_acc_reg, perr_reg, ferr_reg;
  logic [MAX_DATA-1:0] data_reg;
  logic start_det, at_s0, at_s1, at_mid, at_end, vote, last_bit, push;

  // Two-flop synchroniser; everything downstream only looks at rx_s_reg.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
      rx_prev_reg <= rx_s_reg;
    end
  end

  assign start_det = rx_prev_reg & ~rx_s_reg;
  assign half      = period_reg >> 1;
  assign at_s0     = (cnt_reg == half - CNT_W'(1));
  assign at_s1     = (cnt_reg == half);
  assign at_mid    = (cnt_reg == half + CNT_W'(1));
  assign at_end    = (cnt_reg == period_reg - CNT_W'(1));
  // The third sample is the live line value in the at_mid cycle.
  assign vote      = (s0_reg & s1_reg) | (s0_reg & rx_s_reg) | (s1_reg & rx_s_reg);
  assign last_bit  = (bit_idx_reg == len_reg - 4'd1);
  assign len_eff   = (data_len < 4'd5 || data_len > MAX_LEN) ? MAX_LEN : data_len;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // FSM: next state. Stop bits leave at the mid-bit vote so the word is pushed early;
  // all other bits run to the end of their period.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (start_det) state_next = S_START;
      S_START: begin
        if (at_mid && vote) state_next = S_IDLE;      // false start
        else if (at_end)    state_next = S_DATA;
      end
      S_DATA:    if (at_end && last_bit) state_next = par_en_reg ? S_PARITY : S_STOP1;
      S_PARITY:  if (at_end) state_next = S_STOP1;
      S_STOP1: begin
        if (at_mid) begin
          if (!vote)           state_next = S_WAIT_HI;
          else if (!stop2_reg) state_next = S_PUSH;
        end else if (at_end) begin
          state_next = S_STOP2;                        // only reached with stop2 and a good stop
        end
      end
      S_STOP2:   if (at_mid) state_next = vote ? S_PUSH : S_WAIT_HI;
      S_WAIT_HI: if (rx_s_reg) state_next = S_PUSH;
      S_PUSH:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_reg != S_IDLE);
    push = (state_reg == S_PUSH);
  end

  // Bit timing, frame configuration and error accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      period_reg  <= CNT_W'(CLK_PER_BIT);
      len_reg     <= MAX_LEN;
      par_en_reg  <= 1'b0;
      par_odd_reg <= 1'b0;
      stop2_reg   <= 1'b0;
      bit_idx_reg <= '0;
      s0_reg      <= 1'b1;
      s1_reg      <= 1'b1;
      par_acc_reg <= 1'b0;
      perr_reg    <= 1'b0;
      ferr_reg    <= 1'b0;
    end else if (state_reg == S_IDLE) begin
      if (start_det) begin
        // The detection cycle is count 0 of the start bit.
        cnt_reg     <= CNT_W'(1);
        period_reg  <= CNT_W'(CLK_PER_BIT) << baud_sel;
        len_reg     <= len_eff;
        par_en_reg  <= parity_en;
        par_odd_reg <= parity_odd;
        stop2_reg   <= stop2;
        bit_idx_reg <= '0;
        par_acc_reg <= 1'b0;
        perr_reg    <= 1'b0;
        ferr_reg    <= 1'b0;
      end
    end else begin
      cnt_reg <= at_end ? '0 : cnt_reg + CNT_W'(1);
      if (at_s0) s0_reg <= rx_s_reg;
      if (at_s1) s1_reg <= rx_s_reg;
      if (state_reg == S_DATA && at_mid) par_acc_reg <= par_acc_reg ^ vote;
      if (state_reg == S_DATA && at_end) bit_idx_reg <= bit_idx_reg + 4'd1;
      if (state_reg == S_PARITY && at_mid) perr_reg <= ((par_acc_reg ^ vote) != par_odd_reg);
      if ((state_reg == S_STOP1 || state_reg == S_STOP2) && at_mid && !vote) ferr_reg <= 1'b1;
    end
  end

  // Data bits land directly at their final position, so short words are right-aligned
  // and the unused upper bits stay at the zero they were cleared to at the start edge.
  for (genvar gi = 0; gi < MAX_DATA; gi++) begin : g_data
    always_ff @(posedge clk) begin
      if (rst)
        data_reg[gi] <= 1'b0;
      else if (state_reg == S_IDLE && start_det)
        data_reg[gi] <= 1'b0;
      else if (state_reg == S_DATA && at_mid && bit_idx_reg == 4'(gi))
        data_reg[gi] <= vote;
    end
  end

  // Show-ahead FIFO. Pointers carry one extra wrap bit to tell full from empty.
  logic [ENTRY_W-1:0] mem_reg [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr_reg, rd_ptr_reg;
  logic [ENTRY_W-1:0] head;
  logic empty, full, pop, push_ok, overrun_reg;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                   (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign pop     = ~empty & rd_ready;
  // A pop in the same cycle frees the slot, so a push onto a full FIFO is still accepted.
  assign push_ok = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg[PTR_W-1:0]] <= {ferr_reg, perr_reg, data_reg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      overrun_reg <= push & full & ~pop;
    end
  end

  // Head outputs are forced to zero while empty so stale memory never shows.
  assign head     = mem_reg[rd_ptr_reg[PTR_W-1:0]];
  assign rd_valid = ~empty;
  assign rd_data  = empty ? '0 : head[MAX_DATA-1:0];
  assign rd_perr  = ~empty & head[MAX_DATA];
  assign rd_ferr  = ~empty & head[MAX_DATA+1];
  assign overrun  = overrun_reg;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed testbench for uart_rx_cfg (CLK_PER_BIT=32, MAX_DATA=9, FIFO_DEPTH=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_rx_cfg;
  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [1:0] baud_sel;
  logic [3:0] data_len;
  logic       parity_en, parity_odd, stop2;
  logic [8:0] rd_data;
  logic       rd_perr, rd_ferr, rd_valid, rd_ready, overrun, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ovr_cnt = 0;
  int ovr_base, t0, lat;

  uart_rx_cfg #(.CLK_PER_BIT(32), .MAX_DATA(9), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rx(rx), .baud_sel(baud_sel), .data_len(data_len),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .rd_data(rd_data), .rd_perr(rd_perr), .rd_ferr(rd_ferr), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (overrun) ovr_cnt <= ovr_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b, input int cpb);
    rx = b;
    repeat (cpb) @(negedge clk);
  endtask

  task automatic send_frame(input logic [8:0] d, input int nbits, input logic pen,
                            input logic pbit, input int nstop, input int cpb);
    drive_bit(1'b0, cpb);
    for (int i = 0; i < nbits; i++) drive_bit(d[i], cpb);
    if (pen) drive_bit(pbit, cpb);
    for (int i = 0; i < nstop; i++) drive_bit(1'b1, cpb);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!rd_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, rd_valid, 1);
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [8:0] d, input logic pe, input logic fe);
    wait_valid({tag, "_valid"}, 1200);
    chk({tag, "_data"}, rd_data, d);
    chk({tag, "_perr"}, rd_perr, pe);
    chk({tag, "_ferr"}, rd_ferr, fe);
    $display("word %s: data=%03h perr=%0b ferr=%0b", tag, rd_data, rd_perr, rd_ferr);
    pop_one();
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; baud_sel = 2'd0; data_len = 4'd8;
    parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b0; rd_ready = 1'b0;
    idle(5);
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_perr", rd_perr, 0);
    chk("rst_ferr", rd_ferr, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    idle(5);

    // 1: 8E1 at 32 clk/bit; 0x3A has four ones -> even parity bit 0
    fork
      send_frame(9'h03A, 8, 1'b1, 1'b0, 1, 32);
      begin
        t0 = cyc;
        wait_valid("t1_valid", 400);
        lat = cyc - t0;
      end
    join
    chk("t1_latency_ok", lat <= 12 * 32 + 4, 1);
    expect_word("t1", 9'h03A, 1'b0, 1'b0);
    chk("t1_empty", rd_valid, 0);

    // 2: baud_sel=1 -> 64 clk/bit
    baud_sel = 2'd1;
    send_frame(9'h03A, 8, 1'b1, 1'b0, 1, 64);
    expect_word("t2_ok", 9'h03A, 1'b0, 1'b0);
    // 0x7A (five ones, even parity bit 1) sent at the wrong rate
    send_frame(9'h07A, 8, 1'b1, 1'b1, 1, 32);
    wait_valid("t2_bad_valid", 1000);
    chk("t2_garbled", (rd_data != 9'h07A) || rd_ferr, 1);
    $display("word t2_bad: data=%03h ferr=%0b", rd_data, rd_ferr);
    pop_one();
    idle(5);
    chk("t2_idle", busy, 0);
    baud_sel = 2'd0;

    // 3: 6 data bits 111010 (four ones -> even parity 0)
    data_len = 4'd6;
    send_frame(9'h03A, 6, 1'b1, 1'b0, 1, 32);
    expect_word("t3", 9'h03A, 1'b0, 1'b0);
    data_len = 4'd8;

    // 4: odd parity expected; even-parity frame flags perr
    parity_odd = 1'b1;
    send_frame(9'h03A, 8, 1'b1, 1'b0, 1, 32);
    expect_word("t4_even", 9'h03A, 1'b1, 1'b0);
    send_frame(9'h03A, 8, 1'b1, 1'b1, 1, 32);
    expect_word("t4_odd", 9'h03A, 1'b0, 1'b0);
    parity_en = 1'b0; parity_odd = 1'b0;
    send_frame(9'h03A, 8, 1'b0, 1'b0, 1, 32);
    expect_word("t4_nopar", 9'h03A, 1'b0, 1'b0);

    // 5: two stop bits
    stop2 = 1'b1;
    send_frame(9'h03A, 8, 1'b0, 1'b0, 2, 32);
    expect_word("t5_2stop", 9'h03A, 1'b0, 1'b0);
    // one stop bit, then the line drops for a start bit -> second stop reads 0
    send_frame(9'h03A, 8, 1'b0, 1'b0, 1, 32);
    drive_bit(1'b0, 32);
    rx = 1'b1;
    expect_word("t5_ferr", 9'h03A, 1'b0, 1'b1);
    idle(50);
    chk("t5_single_entry", rd_valid, 0);
    // 8-clock glitch is rejected as a false start
    rx = 1'b0;
    idle(8);
    rx = 1'b1;
    idle(100);
    chk("t5_glitch_valid", rd_valid, 0);
    chk("t5_glitch_busy", busy, 0);
    // reset in the middle of a frame, with a word already queued
    send_frame(9'h055, 8, 1'b0, 1'b0, 2, 32);
    chk("t5_queued", rd_valid, 1);
    drive_bit(1'b0, 96);
    chk("t5_midframe_busy", busy, 1);
    rx = 1'b1;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    chk("t5_rst_valid", rd_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_data", rd_data, 0);
    stop2 = 1'b0;

    // 6: overflow with 8E1 frames, no pops
    parity_en = 1'b1;
    idle(10);
    ovr_base = ovr_cnt;
    send_frame(9'h011, 8, 1'b1, 1'b0, 1, 32);
    send_frame(9'h022, 8, 1'b1, 1'b0, 1, 32);
    send_frame(9'h033, 8, 1'b1, 1'b0, 1, 32);
    send_frame(9'h044, 8, 1'b1, 1'b0, 1, 32);
    send_frame(9'h055, 8, 1'b1, 1'b0, 1, 32);
    idle(2);
    chk("t6_overrun_once", ovr_cnt - ovr_base, 1);
    chk("t6_head", rd_data, 9'h011);
    // PUSH for a frame whose start edge is driven at negedge 0 falls in the cycle
    // after negedge 340: 2 sync cycles + 10 bits + 17 clocks to the last stop sample.
    fork
      send_frame(9'h066, 8, 1'b1, 1'b0, 1, 32);
      begin
        repeat (340) @(negedge clk);
        chk("t6_full_head", rd_data, 9'h011);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
      end
    join
    idle(2);
    chk("t6_no_new_overrun", ovr_cnt - ovr_base, 1);
    expect_word("t6_w1", 9'h022, 1'b0, 1'b0);
    expect_word("t6_w2", 9'h033, 1'b0, 1'b0);
    expect_word("t6_w3", 9'h044, 1'b0, 1'b0);
    expect_word("t6_w4", 9'h066, 1'b0, 1'b0);
    chk("t6_drained", rd_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
